eight_bit_down_timer: RTL and testbench
=======================================

// Module: eight_bit_down_timer
// PURPOSE
//   Loadable down-counter/timer that counts in the opposite direction to the
//   team's 8-bit up counter. It counts a loaded value down to zero and flags
//   terminal count, with one-shot or auto-reload operation. It sits beside the
//   up counter in the lab designs as the delay/timeout source for
//   display-refresh and blink logic.
// PARAMETERS
//   WIDTH        8    counter / load value width in bits
// PORTS
//   clock        in   1      rising-edge clock; the only clock
//   clear        in   1      synchronous, active-low reset (sampled on posedge clock)
//   load         in   1      load load_value into counter and reload register
//   load_value   in   WIDTH  start / reload value
//   enable       in   1      count-down enable, one decrement per enabled cycle
//   auto_reload  in   1      1: reload on terminal count; 0: one-shot, stop at 0
//   out          out  WIDTH  current count (registered)
//   zero         out  1      combinational, out == 0
//   done         out  1      registered one-cycle terminal-count pulse
//   busy         out  1      registered, 1 while state == RUN
// BEHAVIOUR
//   - Single clock domain.
//   - Reset: clear is synchronous and active-low. When clear==0 at posedge:
//     out=0, reload_reg=0, done=0, busy=0, state=IDLE.
//   - States: IDLE (holding, not counting) and RUN (counting down).
//   - Priority per edge: clear > load > enable.
//   - Load, accepted in any state:
//       out<=load_value; reload_reg<=load_value; done<=0.
//       Next state is RUN if load_value != 0, else IDLE.
//       New value is visible 1 cycle after the load edge.
//   - RUN, enable=1, out>1: out<=out-1; done<=0.
//   - RUN, enable=1, out==1 (terminal decrement): done<=1 for exactly one cycle.
//       auto_reload=1: out<=reload_reg; stay in RUN.
//       auto_reload=0: out<=0; go to IDLE (busy falls on the same edge
//       that done rises).
//   - RUN, enable=0: out holds; done<=0.
//   - IDLE: out holds. enable is ignored. The counter never wraps below 0
//     (no 0 -> 2^WIDTH-1 transition ever).
//   - auto_reload is sampled only at the terminal-decrement edge. It may
//     change at any other time without effect.
//   - reload_reg==1 with auto_reload=1: out stays 1 and done pulses on every
//     enabled cycle.
//   - done is never high for two consecutive cycles unless consecutive enabled
//     terminal decrements occur (reload value 1).
//   - Arithmetic: WIDTH-bit unsigned. Loading 2^WIDTH-1 takes 2^WIDTH-1
//     enabled cycles to reach done.
//   - clear mid-count aborts immediately. No done pulse is generated.
// TESTING
//   1. clear=0 for 2 cycles, then 1
//      -> out=0, zero=1, busy=0, done=0; enable=1 alone leaves out=0.
//   2. load 5, then enable=1 held, auto_reload=0
//      -> out 5,4,3,2,1,0; done=1 only in the out=0 cycle; busy 1->0 on that
//      edge; out stays 0 afterwards.
//   3. auto_reload=1, load 3, enable=1 held
//      -> out 3,2,1,3,2,1,3...; done pulses every 3rd enabled cycle, coincident
//      with the 1->3 transition.
//   4. load 4, then enable pattern 1,0,1,1
//      -> out 4,3,3,2,1; done stays 0.
//   5. load 0 -> out=0, zero=1, busy=0, done never asserts.
//      While counting at 7, load=1 with load_value=2 and enable=1 -> out=2
//      (load wins). While counting, clear=0 with load=1 -> out=0, busy=0
//      (clear wins).
//   6. WIDTH=8, load 255, enable held
//      -> done asserts exactly 255 cycles after the load edge; no wrap to 255
//      afterwards.

Source files
------------

// File: rtl/eight_bit_down_timer.sv
// Loadable down-counter / timer with one-shot or auto-reload operation.
// Counts a loaded value down to zero and pulses done on the terminal decrement.
module eight_bit_down_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q;

    // Next-state logic: load takes priority over counting.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? StRun : StIdle;
        end else if (state_q == StRun && enable) begin
            if (count_q == CountOne) begin
                // Terminal decrement: auto_reload is only looked at here.
                done_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = StIdle;
                end
            end else if (count_q == '0) begin
                // Unreachable in normal use; never wrap below zero.
                state_d = StIdle;
            end else begin
                count_d = count_q - CountOne;
            end
        end
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            // Registered copy of (state == RUN), tracking the state register.
            busy_q   <= (state_d == StRun);
        end
    end

    assign out  = count_q;
    assign zero = (count_q == '0);
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_eight_bit_down_timer.sv
// Scoreboard bench for eight_bit_down_timer: the stimulus process pushes the
// expected post-edge outputs, a monitor pops and compares after every edge.
module tb_eight_bit_down_timer;

    logic       clock;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       auto_reload;
    logic [7:0] out;
    logic       zero;
    logic       done;
    logic       busy;

    typedef struct {
        logic [7:0] out;
        logic       zero;
        logic       done;
        logic       busy;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    eight_bit_down_timer #(.WIDTH(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .out         (out),
        .zero        (zero),
        .done        (done),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs for the coming edge, record what must be seen after it.
    task automatic step(input string name, input logic clr, input logic ld,
                        input logic [7:0] lv, input logic en, input logic ar,
                        input logic [7:0] e_out, input logic e_done, input logic e_busy);
        exp_t e;
        clear       = clr;
        load        = ld;
        load_value  = lv;
        enable      = en;
        auto_reload = ar;
        e.out  = e_out;
        e.zero = (e_out == 8'd0);
        e.done = e_done;
        e.busy = e_busy;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e.out || zero !== e.zero || done !== e.done || busy !== e.busy) begin
                    errors++;
                    $display("FAIL %s: got out=%0d zero=%b done=%b busy=%b, want out=%0d zero=%b done=%b busy=%b",
                             e.name, out, zero, done, busy, e.out, e.zero, e.done, e.busy);
                end
            end
        end
    end

    initial begin
        // 1. reset, then enable alone does nothing
        step("reset0",      0, 0, 8'd0, 0, 0, 8'd0, 0, 0);
        step("reset1",      0, 0, 8'd0, 0, 0, 8'd0, 0, 0);
        step("idle_en0",    1, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        step("idle_en1",    1, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // 2. one-shot from 5
        step("os_load5",    1, 1, 8'd5, 1, 0, 8'd5, 0, 1);
        step("os_4",        1, 0, 8'd0, 1, 0, 8'd4, 0, 1);
        step("os_3",        1, 0, 8'd0, 1, 0, 8'd3, 0, 1);
        step("os_2",        1, 0, 8'd0, 1, 0, 8'd2, 0, 1);
        step("os_1",        1, 0, 8'd0, 1, 0, 8'd1, 0, 1);
        step("os_term",     1, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        step("os_hold0",    1, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        step("os_hold1",    1, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // 3. auto-reload from 3
        step("ar_load3",    1, 1, 8'd3, 1, 1, 8'd3, 0, 1);
        step("ar_2a",       1, 0, 8'd0, 1, 1, 8'd2, 0, 1);
        step("ar_1a",       1, 0, 8'd0, 1, 1, 8'd1, 0, 1);
        step("ar_reload_a", 1, 0, 8'd0, 1, 1, 8'd3, 1, 1);
        step("ar_2b",       1, 0, 8'd0, 1, 1, 8'd2, 0, 1);
        step("ar_1b",       1, 0, 8'd0, 1, 1, 8'd1, 0, 1);
        step("ar_reload_b", 1, 0, 8'd0, 1, 1, 8'd3, 1, 1);
        // auto_reload toggled away from terminal edge has no effect
        step("ar_toggle",   1, 0, 8'd0, 1, 0, 8'd2, 0, 1);

        // 4. gated enable pattern 1,0,1,1 from 4
        step("gate_load4",  1, 1, 8'd4, 0, 0, 8'd4, 0, 1);
        step("gate_e1",     1, 0, 8'd0, 1, 0, 8'd3, 0, 1);
        step("gate_e0",     1, 0, 8'd0, 0, 0, 8'd3, 0, 1);
        step("gate_e1b",    1, 0, 8'd0, 1, 0, 8'd2, 0, 1);
        step("gate_e1c",    1, 0, 8'd0, 1, 0, 8'd1, 0, 1);

        // 5. load 0, load priority, clear priority
        step("load0",       1, 1, 8'd0, 1, 0, 8'd0, 0, 0);
        step("load0_en",    1, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        step("load9",       1, 1, 8'd9, 0, 0, 8'd9, 0, 1);
        step("run_8",       1, 0, 8'd0, 1, 0, 8'd8, 0, 1);
        step("run_7",       1, 0, 8'd0, 1, 0, 8'd7, 0, 1);
        step("load_wins",   1, 1, 8'd2, 1, 0, 8'd2, 0, 1);
        step("clear_wins",  0, 1, 8'd6, 1, 0, 8'd0, 0, 0);
        step("after_clear", 1, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // reload value 1: done every enabled cycle, one-shot takes over at terminal edge
        step("r1_load",     1, 1, 8'd1, 0, 1, 8'd1, 0, 1);
        step("r1_term_a",   1, 0, 8'd0, 1, 1, 8'd1, 1, 1);
        step("r1_term_b",   1, 0, 8'd0, 1, 1, 8'd1, 1, 1);
        step("r1_pause",    1, 0, 8'd0, 0, 1, 8'd1, 0, 1);
        step("r1_oneshot",  1, 0, 8'd0, 1, 0, 8'd0, 1, 0);

        // 6. full-range count from 255
        step("full_load",   1, 1, 8'd255, 1, 0, 8'd255, 0, 1);
        for (int k = 1; k < 255; k++) begin
            step("full_count", 1, 0, 8'd0, 1, 0, 8'(255 - k), 0, 1);
        end
        step("full_term",   1, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        step("full_nowrap0", 1, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        step("full_nowrap1", 1, 0, 8'd0, 1, 1, 8'd0, 0, 0);

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
